// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier.
// Holds the FSM state encoding, operand width and product width.
package shift_add_multiplier_pkg;

    localparam int BITS   = 4;
    localparam int PROD_W = 2 * BITS;
    localparam int STEP_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_multiplier_four_bit_adder.sv
// four_bit_adder: 4-bit ripple-carry adder built from full-adder equations.
module four_bit_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       CarryIN,
    output logic [3:0] Sum,
    output logic       CarryOUT
);

    // Ripple the carry through four full-adder stages.
    always_comb begin
        logic [4:0] c;
        c    = '0;
        Sum  = '0;
        c[0] = CarryIN;
        for (int unsigned i = 0; i < 4; i++) begin
            Sum[i]   = A[i] ^ B[i] ^ c[i];
            c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
        CarryOUT = c[4];
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential 4x4 unsigned multiplier.
// One add-and-shift step per RUN cycle; four steps per operation.
// Optional macro MULT_ZERO_BYPASS_EN: a zero operand skips RUN and goes
// straight to DONE with a zero product.
module shift_add_multiplier #(
    parameter int BITS = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    input  logic [BITS-1:0]     A,
    input  logic [BITS-1:0]     B,
    output logic                Busy,
    output logic                Done,
    output logic [2*BITS-1:0]   Product
);

    import shift_add_multiplier_pkg::*;

    state_t              r_state;
    state_t              w_next;
    logic [BITS-1:0]     r_mcand;
    logic [2*BITS:0]     r_prod;     // {carry, high, low}
    logic [STEP_W-1:0]   r_cnt;
    logic [PROD_W-1:0]   r_product;

    logic                w_accept;
    logic                w_bypass;
    logic [BITS-1:0]     w_addend;
    logic [BITS-1:0]     w_sum;
    logic                w_cout;
    logic [2*BITS:0]     w_shift;
    logic                w_unused_carry;

    // Add the multiplicand only when the current low bit is set.
    assign w_addend = r_prod[0] ? r_mcand : '0;

    four_bit_adder u_adder (
        .A        (r_prod[2*BITS-1:BITS]),
        .B        (w_addend),
        .CarryIN  (1'b0),
        .Sum      (w_sum),
        .CarryOUT (w_cout)
    );

    // The carry joins the shifted value so 15*15 keeps its top bit.
    assign w_shift = {1'b0, w_cout, w_sum, r_prod[BITS-1:1]};

    // Register bit 8 is always zero after a shift; kept for the 9-bit layout.
    assign w_unused_carry = r_prod[2*BITS];

    assign Product = r_product;

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, acceptance and status outputs.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_bypass = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                Done   = (r_state == DONE);
                w_next = IDLE;
                if (Start) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
`ifdef MULT_ZERO_BYPASS_EN
                    if ((A == '0) || (B == '0)) begin
                        w_bypass = 1'b1;
                        w_next   = DONE;
                    end
`endif
                end
            end
            RUN: begin
                Busy = 1'b1;
                if (r_cnt == '1) begin
                    w_next = DONE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        if (Reset) begin
            w_next = IDLE;
        end
    end

    // Operand capture, add-and-shift steps and product update.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_mcand   <= '0;
            r_prod    <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_mcand <= A;
            r_prod  <= {1'b0, {BITS{1'b0}}, B};
            r_cnt   <= '0;
            if (w_bypass) begin
                r_product <= '0;
            end
        end else if (r_state == RUN) begin
            r_prod <= w_shift;
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == '1) begin
                r_product <= w_shift[PROD_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier.
// Honours MULT_ZERO_BYPASS_EN when defined for the build.
module tb_shift_add_multiplier;

    logic       clk;
    logic       Reset;
    logic       Start;
    logic [3:0] A;
    logic [3:0] B;
    logic       Busy;
    logic       Done;
    logic [7:0] Product;

`ifdef MULT_ZERO_BYPASS_EN
    localparam int BYPASS        = 1;
    localparam int EXP_ZERO_DONE = 1;
    localparam int EXP_ZERO_BUSY = 0;
    localparam int EXP_TOTAL     = 31 * 1 + 225 * 5;
`else
    localparam int BYPASS        = 0;
    localparam int EXP_ZERO_DONE = 5;
    localparam int EXP_ZERO_BUSY = 4;
    localparam int EXP_TOTAL     = 256 * 5;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    shift_add_multiplier #(.BITS(4)) dut (
        .Clk     (clk),
        .Reset   (Reset),
        .Start   (Start),
        .A       (A),
        .B       (B),
        .Busy    (Busy),
        .Done    (Done),
        .Product (Product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Behavioural model: phase 0 idle, 1..4 busy, 5 done.
    int m_phase = 0;
    int m_prod  = 0;
    int m_pend  = 0;
    int m_acc   = 0;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        if (Reset) begin
            m_phase = 0;
            m_prod  = 0;
            m_valid = 1'b1;
        end else if (Start && !(m_phase >= 1 && m_phase <= 4)) begin
            m_acc++;
            m_pend = int'(A) * int'(B);
            if (BYPASS != 0 && (A == 4'd0 || B == 4'd0)) begin
                m_phase = 5;
                m_prod  = 0;
            end else begin
                m_phase = 1;
            end
        end else if (m_phase >= 1 && m_phase <= 3) begin
            m_phase++;
        end else if (m_phase == 4) begin
            m_phase = 5;
            m_prod  = m_pend;
        end else begin
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy",    int'(Busy),    (m_phase >= 1 && m_phase <= 4) ? 1 : 0);
            chk("done",    int'(Done),    (m_phase == 5) ? 1 : 0);
            chk("product", int'(Product), m_prod);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          output int busy_n, output int done_t, output int prod);
        A = a; B = b; Start = 1'b1;
        busy_n = 0; done_t = 0; prod = -1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (t == 1) begin
                Start = 1'b0;
                A = 4'($urandom);
                B = 4'($urandom);
            end
            if (Busy) busy_n++;
            if (Done) begin
                done_t = t;
                prod   = int'(Product);
                break;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int bn, dt, pr, cnt, idx, acc0, cyc, dones;

        Reset = 1'b1; Start = 1'b0; A = '0; B = '0;
        tick(); tick();
        chk("rst_busy",    int'(Busy),    0);
        chk("rst_done",    int'(Done),    0);
        chk("rst_product", int'(Product), 0);
        Reset = 1'b0;
        tick();

        // 3*5: four busy cycles, done on the fifth, product held.
        run_op(4'd3, 4'd5, bn, dt, pr);
        chk("3x5_busy_cycles", bn, 4);
        chk("3x5_done_tick",   dt, 5);
        chk("3x5_product",     pr, 8'h0F);
        for (int i = 0; i < 3; i++) tick();
        chk("3x5_held",        int'(Product), 8'h0F);
        chk("3x5_model",       m_prod, 15);

        run_op(4'd15, 4'd15, bn, dt, pr);
        chk("15x15_product", pr, 8'hE1);
        chk("15x15_model",   m_prod, 225);
        run_op(4'd15, 4'd1, bn, dt, pr);
        chk("15x1_product",  pr, 8'h0F);
        run_op(4'd1, 4'd15, bn, dt, pr);
        chk("1x15_product",  pr, 8'h0F);

        run_op(4'd0, 4'd9, bn, dt, pr);
        chk("0x9_product",   pr, 0);
        chk("0x9_done_tick", dt, EXP_ZERO_DONE);
        chk("0x9_busy",      bn, EXP_ZERO_BUSY);
        tick(); tick();

        // Start during RUN is ignored.
        A = 4'd2; B = 4'd3; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        A = 4'd7; B = 4'd7; Start = 1'b1;
        tick();
        Start = 1'b0;
        pr = -1;
        for (int t = 0; t < 20; t++) begin
            if (Done) begin
                pr = int'(Product);
                break;
            end
            tick();
        end
        chk("ignore_start_product", pr, 8'h06);
        tick(); tick();

        // Reset mid-RUN abandons the operation.
        A = 4'd9; B = 4'd9; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("midrst_busy",    int'(Busy),    0);
        chk("midrst_done",    int'(Done),    0);
        chk("midrst_product", int'(Product), 0);
        cnt = 0;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (Done) cnt++;
        end
        chk("midrst_no_done", cnt, 0);

        // Exhaustive back-to-back, Start held high through each DONE.
        idx = 0; A = 4'd0; B = 4'd0; Start = 1'b1;
        acc0 = m_acc; cyc = 0; dones = 0;
        while (dones < 256 && cyc < 3000) begin
            tick();
            cyc++;
            if (Done) dones++;
            if (m_acc != acc0) begin
                acc0 = m_acc;
                idx++;
                if (idx < 256) begin
                    A = 4'(idx >> 4);
                    B = 4'(idx);
                end else begin
                    Start = 1'b0;
                end
            end
        end
        chk("exh_done_count", dones, 256);
        chk("exh_cycles",     cyc,   EXP_TOTAL);
        chk("exh_last",       int'(Product), 225);
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 Parameter: BITS, 4, operand width; only 4 is supported because the datapath instantiates four_bit_adder.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  request to begin a multiply; sampled on rising edge of Clk.
REQ-005 A  input  4  multiplicand, unsigned; sampled only on an accepted Start.
REQ-006 B  input  4  multiplier, unsigned; sampled only on an accepted Start.
REQ-007 Busy  output  1  high while an operation is in progress.
REQ-008 Done  output  1  single-cycle pulse when Product becomes valid.
REQ-009 Product  output  8  unsigned A*B; held stable from Done until the next accepted Start.

Function
REQ-010 The FSM SHALL have states IDLE, RUN and DONE.
REQ-011 Start in IDLE or DONE SHALL be accepted; Start in RUN SHALL be ignored, with no effect on state, counter or operands.
REQ-012 On acceptance: latch A into the multiplicand register; load the 9-bit product register {carry=0, high=0000, low=B}; clear the 2-bit step counter; enter RUN.
REQ-013 Each RUN cycle: if low[0]=1, high = high + multiplicand via four_bit_adder with CarryIN=0, capturing CarryOUT; otherwise add 0. Shift {CarryOUT, sum, low} right by one into the product register.
REQ-014 After exactly 4 RUN cycles (counter wraps 3->0), the FSM SHALL enter DONE.
REQ-015 Latency: with Start accepted at edge N, Busy SHALL be high for the cycles following edges N..N+3, and Done and a valid Product SHALL be present for the cycle following edge N+4.
REQ-016 Done SHALL be high only in DONE. DONE SHALL last one cycle, then return to IDLE unless Start is high.
REQ-017 Busy SHALL be high in RUN only.
REQ-018 Product SHALL update only on the transition into DONE; A and B changes at any other time SHALL have no effect.
REQ-019 A Start coincident with DONE SHALL be accepted: Done pulses that cycle and Busy rises the next cycle.
REQ-020 Worst case 15*15 SHALL yield 225 with no truncation; the carry bit is part of the shifted value.

Reset
REQ-021 Reset SHALL take priority over Start in all states, including mid-RUN.
REQ-022 On Reset: state=IDLE, Busy=0, Done=0, Product=8'h00, counter=0, internal registers=0.
REQ-023 An operation interrupted by Reset SHALL be abandoned, with no Done pulse.

Configuration
REQ-024 Macro MULT_ZERO_BYPASS_EN: when defined, an accepted Start with A=0 or B=0 SHALL go directly to DONE with Product=0. Done appears one cycle after acceptance and Busy stays low.
REQ-025 When MULT_ZERO_BYPASS_EN is undefined, zero operands SHALL take the full 4-cycle RUN path of REQ-015.

Structure
REQ-026 The shared package SHALL hold the state enum (IDLE, RUN, DONE), the BITS constant (4) and the product width (2*BITS).
REQ-027 The single sub-module SHALL be four_bit_adder (ports A, B, CarryIN, Sum, CarryOUT), instantiated once. No other arithmetic operator SHALL be used for the accumulate step.

Verification
REQ-028 Reset, then A=3, B=5, Start for one cycle -> Busy high 4 cycles, Done pulse on the 5th cycle, Product=8'h0F, Product held afterwards.
REQ-029 A=15, B=15 -> Product=8'hE1 (225); A=15, B=1 -> 8'h0F; A=1, B=15 -> 8'h0F.
REQ-030 A=0, B=9 -> Product=0; Done at cycle 1 with MULT_ZERO_BYPASS_EN defined, at cycle 5 without it.
REQ-031 A=2, B=3 started; at RUN cycle 2 drive Start with A=7, B=7 -> ignored, Product=8'h06.
REQ-032 A=9, B=9 started; Reset asserted at RUN cycle 2 -> next cycle Busy=0, Done=0, Product=0, and no Done pulse follows.
REQ-033 Exhaustive 256 A/B pairs, with back-to-back Start asserted in DONE -> every Product equals A*B, with no idle gap between operations.
